// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the fetch/decode pipeline register:
//   - payload field widths (PC, instruction, PC+4) and the total payload width
//   - default payload driven when a stage is empty or flushed
//   - pipeline stage state encoding (EMPTY / ONE / FULL)
//   - helper mapping a stage state to its entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int PC4_W     = 32;
    localparam int PAYLOAD_W = PC_W + INSTR_W + PC4_W;

    localparam logic [PAYLOAD_W-1:0] FLUSH_DATA_DEFAULT = {PAYLOAD_W{1'b0}};

    // Encoding equals the number of held entries so occupancy is a direct copy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] state_occupancy(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// -----------------------------------------------------------------------------
// skid_buf
// Two-entry payload storage for the pipeline stage: MAIN (presented downstream)
// and SKID (catches the payload accepted while downstream is blocked). The
// control (state, push, pop) comes from the owning stage; this block only
// moves payloads. Empty slots hold FLUSH_DATA so MAIN can drive out_data
// directly.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   flush, stall      kill (wins) and freeze requests
//   push, pop         input / output transfer this cycle
//   state             current stage state
//   in_data           upstream payload
//   main_data         payload in MAIN (registered)
// -----------------------------------------------------------------------------
module skid_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = PAYLOAD_W,
    parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(FLUSH_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              push,
    input  logic              pop,
    input  pipe_state_e       state,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] main_data
);

    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] main_next_s;
    logic [DATA_W-1:0] skid_next_s;

    // Next MAIN/SKID contents from the current state and transfers.
    always_comb begin
        main_next_s = main_data_r;
        skid_next_s = skid_data_r;
        if (flush) begin
            main_next_s = FLUSH_DATA;
            skid_next_s = FLUSH_DATA;
        end else if (stall) begin
            main_next_s = main_data_r;
            skid_next_s = skid_data_r;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        main_next_s = in_data;
                    end else begin
                        main_next_s = main_data_r;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_next_s = in_data;
                    end else if (push) begin
                        skid_next_s = in_data;
                    end else if (pop) begin
                        main_next_s = FLUSH_DATA;
                    end else begin
                        main_next_s = main_data_r;
                    end
                end
                ST_FULL: begin
                    // in_ready is low when FULL, so only a pop can occur.
                    if (pop) begin
                        main_next_s = skid_data_r;
                        skid_next_s = FLUSH_DATA;
                    end else begin
                        main_next_s = main_data_r;
                    end
                end
                default: begin
                    main_next_s = FLUSH_DATA;
                    skid_next_s = FLUSH_DATA;
                end
            endcase
        end
    end

    // Payload registers; reset clears both slots to FLUSH_DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data_r <= FLUSH_DATA;
            skid_data_r <= FLUSH_DATA;
        end else begin
            main_data_r <= main_next_s;
            skid_data_r <= skid_next_s;
        end
    end

    assign main_data = main_data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline register with hazard stall and control-hazard flush.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid buffer
// (in_ready independent of out_ready). Without it the stage holds one entry
// and in_ready depends combinationally on out_ready.
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid / in_ready / in_data     upstream handshake and payload
//   out_valid / out_ready / out_data  downstream handshake and payload
//   stall      hold request: freezes state, hides out_valid and in_ready
//   flush      kill request: empties the stage, wins over stall
//   occupancy  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = PAYLOAD_W,
    parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(FLUSH_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    pipe_state_e       state_r;
    pipe_state_e       state_next_s;
    logic              rdy_en_r;
    logic              out_valid_s;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] main_data_s;

    // rdy_en_r keeps in_ready low from reset until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
        end
    end

    assign out_valid_s = (state_r != ST_EMPTY) && !stall;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready_s = rdy_en_r && !stall && (state_r != ST_FULL);
`else
    assign in_ready_s = rdy_en_r && !stall && (!out_valid_s || out_ready);
`endif

    assign push_s = in_valid && in_ready_s;
    assign pop_s  = out_valid_s && out_ready;

    // Next-state logic; flush beats stall, stall freezes everything.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else if (stall) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_next_s = ST_ONE;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && !pop_s) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_next_s = ST_FULL;
`else
                        state_next_s = ST_ONE;
`endif
                    end else if (pop_s && !push_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_FULL: begin
                    if (pop_s) begin
                        state_next_s = ST_ONE;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
`endif
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Stage state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    skid_buf #(
        .DATA_W     (DATA_W),
        .FLUSH_DATA (FLUSH_DATA)
    ) u_skid_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stall     (stall),
        .push      (push_s),
        .pop       (pop_s),
        .state     (state_r),
        .in_data   (in_data),
        .main_data (main_data_s)
    );
`else
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] main_next_s;

    // Single-entry payload update; a push with pop replaces MAIN in place.
    always_comb begin
        main_next_s = main_data_r;
        if (flush) begin
            main_next_s = FLUSH_DATA;
        end else if (stall) begin
            main_next_s = main_data_r;
        end else if (push_s) begin
            main_next_s = in_data;
        end else if (pop_s) begin
            main_next_s = FLUSH_DATA;
        end else begin
            main_next_s = main_data_r;
        end
    end

    // Single-entry payload register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data_r <= FLUSH_DATA;
        end else begin
            main_data_r <= main_next_s;
        end
    end

    assign main_data_s = main_data_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = main_data_s;
    assign occupancy = state_occupancy(state_r);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. Expectations follow the build option:
// with PIPE_STAGE_SKID_EN the stage buffers two entries, otherwise one.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_data = 96'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] out_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    logic [1:0] max_occ = 2'd0;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (occupancy > max_occ) max_occ <= occupancy;
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [95:0] d);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    initial begin
        // Reset state
        #3;
        check_eq("rst_occ", 96'(occupancy), 96'd0);
        check_eq("rst_ovalid", 96'(out_valid), 96'd0);
        check_eq("rst_odata", out_data, 96'd0);
        check_eq("rst_iready", 96'(in_ready), 96'd0);
        #9 reset_n = 1'b1;
        cyc();
        check_eq("post_rst_iready", 96'(in_ready), 96'd1);

        // Streaming with downstream always ready
        out_ready = 1'b1;
        send(96'h10);
        cyc();
        check_eq("s0_data", out_data, 96'h10);
        check_eq("s0_valid", 96'(out_valid), 96'd1);
        check_eq("s0_occ", 96'(occupancy), 96'd1);
        send(96'h14);
        #1 check_eq("s1_iready", 96'(in_ready), 96'd1);
        cyc();
        check_eq("s1_data", out_data, 96'h14);
        check_eq("s1_occ", 96'(occupancy), 96'd1);
        send(96'h18);
        cyc();
        check_eq("s2_data", out_data, 96'h18);
        check_eq("s2_occ", 96'(occupancy), 96'd1);
        in_valid = 1'b0;
        cyc();
        check_eq("s_drain_valid", 96'(out_valid), 96'd0);
        check_eq("s_drain_data", out_data, 96'd0);
        check_eq("s_drain_occ", 96'(occupancy), 96'd0);

        // Backpressure for three cycles while sending A0, A4
        out_ready = 1'b0;
        send(96'hA0);
        cyc();
        send(96'hA4);
        #1 check_eq("bp_iready1", 96'(in_ready), SKID ? 96'd1 : 96'd0);
        cyc();
        check_eq("bp_occ", 96'(occupancy), SKID ? 96'd2 : 96'd1);
        check_eq("bp_data", out_data, 96'hA0);
        #1 check_eq("bp_iready2", 96'(in_ready), 96'd0);
        cyc();
        check_eq("bp_hold_data", out_data, 96'hA0);
        check_eq("bp_hold_valid", 96'(out_valid), 96'd1);
        out_ready = 1'b1;
        // The single-entry build still has A4 waiting upstream.
        in_valid = !SKID;
        cyc();
        check_eq("bp_second_data", out_data, 96'hA4);
        check_eq("bp_second_occ", 96'(occupancy), 96'd1);
        in_valid = 1'b0;
        cyc();
        check_eq("bp_empty_occ", 96'(occupancy), 96'd0);

        // Flush while full, with a same-cycle input B0
        out_ready = 1'b0;
        send(96'hA8);
        cyc();
        send(96'hAC);
        cyc();
        check_eq("fl_pre_occ", 96'(occupancy), SKID ? 96'd2 : 96'd1);
        flush = 1'b1;
        send(96'hB0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", 96'(out_valid), 96'd0);
        check_eq("fl_occ", 96'(occupancy), 96'd0);
        check_eq("fl_data", out_data, 96'd0);
        out_ready = 1'b1;
        cyc();
        check_eq("fl_no_b0_valid", 96'(out_valid), 96'd0);
        check_eq("fl_no_b0_data", out_data, 96'd0);

        // Stall and flush together while ONE: flush wins
        out_ready = 1'b0;
        send(96'hB4);
        cyc();
        in_valid = 1'b0;
        check_eq("sf_pre_occ", 96'(occupancy), 96'd1);
        stall = 1'b1;
        flush = 1'b1;
        #1 check_eq("sf_valid_low", 96'(out_valid), 96'd0);
        cyc();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("sf_occ", 96'(occupancy), 96'd0);
        check_eq("sf_valid", 96'(out_valid), 96'd0);
        check_eq("sf_data", out_data, 96'd0);

        // Stall alone for two cycles holding C0
        send(96'hC0);
        cyc();
        in_valid = 1'b0;
        stall = 1'b1;
        #1;
        check_eq("st_valid", 96'(out_valid), 96'd0);
        check_eq("st_iready", 96'(in_ready), 96'd0);
        check_eq("st_data", out_data, 96'hC0);
        cyc();
        check_eq("st_occ", 96'(occupancy), 96'd1);
        check_eq("st_valid2", 96'(out_valid), 96'd0);
        cyc();
        stall = 1'b0;
        #1;
        check_eq("st_rel_valid", 96'(out_valid), 96'd1);
        check_eq("st_rel_data", out_data, 96'hC0);
        out_ready = 1'b1;
        cyc();
        check_eq("st_done_occ", 96'(occupancy), 96'd0);

        // Asynchronous reset mid-period while full
        out_ready = 1'b0;
        send(96'hD0);
        cyc();
        send(96'hD4);
        cyc();
        in_valid = 1'b0;
        check_eq("ar_pre_occ", 96'(occupancy), SKID ? 96'd2 : 96'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("ar_occ", 96'(occupancy), 96'd0);
        check_eq("ar_valid", 96'(out_valid), 96'd0);
        check_eq("ar_data", out_data, 96'd0);
        check_eq("ar_iready", 96'(in_ready), 96'd0);
        #1 reset_n = 1'b1;
        #1 check_eq("ar_rel_iready", 96'(in_ready), 96'd0);
        cyc();
        check_eq("ar_edge_iready", 96'(in_ready), 96'd1);
        check_eq("ar_edge_occ", 96'(occupancy), 96'd0);

        check_eq("occ_max", 96'(max_occ), SKID ? 96'd2 : 96'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, giving the payload width (PC, instruction, PC+4).
REQ-002 SHALL have parameter FLUSH_DATA, default all-zero, giving the payload driven when the stage is empty or flushed.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning upstream offers a payload.
REQ-006 SHALL have port in_ready, output, 1, meaning the stage accepts this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, the upstream payload.
REQ-008 SHALL have port out_valid, output, 1, meaning the stage presents a payload.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream consumes this cycle.
REQ-010 SHALL have port out_data, output, DATA_W, the presented payload.
REQ-011 SHALL have port stall, input, 1, the hazard-unit hold request.
REQ-012 SHALL have port flush, input, 1, the control-hazard kill request.
REQ-013 SHALL have port occupancy, output, 2, the number of held entries (0..2).

Function
REQ-014 SHALL transfer in when in_valid && in_ready, and transfer out when out_valid && out_ready.
REQ-015 SHALL keep payloads in FIFO order, with one cycle of latency from input transfer to out_valid.
REQ-016 SHALL hold two entries, MAIN (presented) and SKID; states are EMPTY (occ 0), ONE (occ 1, MAIN valid) and FULL (occ 2).
REQ-017 SHALL drive in_ready = !stall && (state != FULL) as a registered-state function with no combinational path from out_ready.
REQ-018 SHALL make these transitions:
- EMPTY + in -> ONE.
- ONE + in + no out -> FULL.
- ONE + out + no in -> EMPTY.
- ONE + in + out -> ONE, with MAIN replaced.
- FULL + out -> ONE, with SKID moving to MAIN.
REQ-019 SHALL, while stall=1, force out_valid=0 and in_ready=0 and freeze all state and out_data.
REQ-020 SHALL, on flush=1 at an edge, discard all entries, go to EMPTY, and drop any same-cycle input transfer.
REQ-021 SHALL give flush priority over stall when both are asserted.
REQ-022 SHALL drive out_data = FLUSH_DATA whenever out_valid=0 (excluding stall freeze).
REQ-023 SHALL, when the downstream is not ready, keep out_data and out_valid stable until consumed (no drop, no reorder).

Reset
REQ-024 SHALL, on reset_n=0 (immediately, asynchronously), force state EMPTY, occupancy=0, out_valid=0 and out_data=FLUSH_DATA.
REQ-025 SHALL also force in_ready=0 while reset_n=0, and in_ready=!stall on the first edge after release.
REQ-026 SHALL discard all in-flight entries on reset asserted mid-operation, including when FULL.

Configuration
REQ-027 SHALL, with macro PIPE_STAGE_SKID_EN defined, implement the two-entry skid behaviour of REQ-016 to REQ-018.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN undefined, use a single entry with in_ready = !stall && (!out_valid || out_ready) (combinational from out_ready), occupancy at most 1, and FULL unreachable.

Structure
REQ-029 SHALL place the pipeline-register payload widths, the default FLUSH_DATA, and the state encoding (EMPTY/ONE/FULL) in the shared package pipe_pkg.
REQ-030 SHALL implement the two-entry storage with its MAIN/SKID muxing as a single sub-module, skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-031 Bench SHALL drive a stream with out_ready=1: in_data 0x10,0x14,0x18 on consecutive cycles -> same values on out_data one cycle later; occupancy stays 1.
REQ-032 Bench SHALL drop out_ready to 0 for 3 cycles while sending 0xA0,0xA4 -> occupancy goes to 2 and in_ready goes to 0; after out_ready returns, 0xA0 then 0xA4 emerge, with nothing lost.
REQ-033 Bench SHALL assert flush while FULL, together with in_valid and 0xB0 -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_DATA, and 0xB0 never appears.
REQ-034 Bench SHALL assert stall and flush together while ONE -> flush wins: EMPTY next cycle.
REQ-035 Bench SHALL assert stall alone for 2 cycles holding 0xC0 -> out_valid=0 and in_ready=0 during the stall; 0xC0 is presented once the stall clears.
REQ-036 Bench SHALL pulse reset_n low mid-clock-period while FULL -> outputs reset immediately, without waiting for a clock edge; the test reruns with PIPE_STAGE_SKID_EN undefined and checks occupancy never exceeds 1.
